// File: rtl/pwm_servo_multi.sv
// Multi-channel servo PWM: one shared frame counter, per-channel position -> pulse width,
// optional per-frame slew limiting, updates latched only at frame boundaries.

module pwm_servo_ch #(
  parameter int POS_W      = 8,
  parameter int CW         = 20,
  parameter int MIN_CYC    = 50000,
  parameter int STEP_CYC   = 196,
  parameter int MAX_CYC    = 100000,
  parameter int SLEW       = 0,
  parameter int RST_POS    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             first,
  input  logic             wrap,
  input  logic [CW-1:0]    cnt,
  input  logic [POS_W-1:0] pos,
  input  logic             en,
  output logic             pwm
);
  localparam int WW = POS_W + CW + 34;

  logic [POS_W-1:0] cur, nxt, diff;
  logic             en_l, en_eff;
  logic [WW-1:0]    raw, w;

  always_comb begin
    diff = (pos > cur) ? pos - cur : cur - pos;
    nxt  = pos;
    if (SLEW != 0 && int'(diff) > SLEW)
      nxt = (pos > cur) ? cur + POS_W'(SLEW) : cur - POS_W'(SLEW);
  end

  always_comb begin
    raw = WW'(MIN_CYC) + WW'(cur) * WW'(STEP_CYC);
    w   = (raw > WW'(MAX_CYC)) ? WW'(MAX_CYC) : raw;
  end

  // Frame 0 has no latched enable yet: the first edge after reset uses en directly.
  assign en_eff = first ? en : en_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= POS_W'(RST_POS);
      en_l <= 1'b0;
      pwm  <= 1'b0;
    end else begin
      if (first) begin
        en_l <= en;
      end else if (wrap) begin
        en_l <= en;
        cur  <= nxt;
      end
      pwm <= en_eff && (WW'(cnt) < w);
    end
  end
endmodule

module pwm_servo_multi #(
  parameter int CH         = 4,
  parameter int POS_W      = 8,
  parameter int PERIOD_CYC = 1000000,
  parameter int MIN_CYC    = 50000,
  parameter int STEP_CYC   = 196,
  parameter int MAX_CYC    = 100000,
  parameter int SLEW       = 0,
  parameter int RST_POS    = 2**(POS_W-1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*POS_W-1:0] pos,
  input  logic [CH-1:0]       en,
  output logic [CH-1:0]       out,
  output logic                frame_start
);
  localparam int CW = $clog2(PERIOD_CYC);

  logic [CW-1:0] cnt;
  logic          pend, wrap;

  assign wrap = (cnt == CW'(PERIOD_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      pend        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pend        <= 1'b0;
      cnt         <= wrap ? '0 : cnt + 1'b1;
      frame_start <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_servo_ch #(
      .POS_W(POS_W), .CW(CW), .MIN_CYC(MIN_CYC), .STEP_CYC(STEP_CYC),
      .MAX_CYC(MAX_CYC), .SLEW(SLEW), .RST_POS(RST_POS)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .first(pend),
      .wrap (wrap),
      .cnt  (cnt),
      .pos  (pos[i*POS_W +: POS_W]),
      .en   (en[i]),
      .pwm  (out[i])
    );
  end
endmodule

// File: tb/tb_pwm_servo_multi.sv
// Directed bench: two instances (no slew / slew=2) measured frame by frame against hand tables.

module tb_pwm_servo_multi;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pa, pb;
  logic [1:0] ena, enb;
  logic [1:0] outa, outb;
  logic       fsa, fsb;

  int ncmp = 0, nerr = 0;
  int mw[4];
  int mbad, mfs_a, mfs_b, mextra;

  always #5 clk = ~clk;

  pwm_servo_multi #(.CH(2), .POS_W(5), .PERIOD_CYC(100), .MIN_CYC(10), .STEP_CYC(1),
                    .MAX_CYC(40), .SLEW(0), .RST_POS(16))
    dut_a (.clk(clk), .rst(rst), .pos(pa), .en(ena), .out(outa), .frame_start(fsa));

  pwm_servo_multi #(.CH(2), .POS_W(5), .PERIOD_CYC(100), .MIN_CYC(10), .STEP_CYC(1),
                    .MAX_CYC(40), .SLEW(2), .RST_POS(16))
    dut_b (.clk(clk), .rst(rst), .pos(pb), .en(enb), .out(outb), .frame_start(fsb));

  task automatic chk(input string tag, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Measures one frame starting at the frame_start cycle; optional stimulus op at sample op_k.
  task automatic measure(input int op_k, input int op);
    int tmo = 0;
    logic [3:0] smp [100];
    while (!fsa && tmo < 300) begin
      @(negedge clk);
      tmo++;
    end
    if (!fsa) begin
      chk("frame_start_timeout", 0, 1);
      return;
    end
    mextra = 0;
    for (int k = 0; k < 100; k++) begin
      smp[k] = {outb, outa};
      if (k > 0 && (fsa || fsb)) mextra++;
      if (k == op_k) begin
        case (op)
          1: begin pa[4:0] = 5'd0; pa[9:5] = 5'd31; pb[4:0] = 5'd0; end
          2: pa[4:0] = 5'd5;
          3: pa[4:0] = 5'd20;
          4: ena[1] = 1'b0;
          default: ;
        endcase
      end
      @(negedge clk);
    end
    mfs_a = int'(fsa);
    mfs_b = int'(fsb);
    for (int s = 0; s < 4; s++) begin
      mw[s] = 0;
      for (int k = 0; k < 100; k++) mw[s] += int'(smp[k][s]);
    end
    mbad = 0;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 100; k++)
        if (smp[k][s] != (k < mw[s])) mbad++;
  endtask

  task automatic check_frame(input string nm, input int e0, input int e1, input int eb0, input int eb1);
    chk($sformatf("%s a0 width", nm), mw[0], e0);
    chk($sformatf("%s a1 width", nm), mw[1], e1);
    chk($sformatf("%s b0 width", nm), mw[2], eb0);
    chk($sformatf("%s b1 width", nm), mw[3], eb1);
    chk($sformatf("%s pulse shape", nm), mbad, 0);
    chk($sformatf("%s period a", nm), mfs_a, 1);
    chk($sformatf("%s period b", nm), mfs_b, 1);
    chk($sformatf("%s extra frame_start", nm), mextra, 0);
  endtask

  int ea0 [10] = '{26, 10, 15, 30, 30, 30, 30, 30, 30, 30};
  int ea1 [10] = '{26, 40, 40, 40,  0,  0,  0,  0,  0,  0};
  int eb0 [10] = '{26, 24, 22, 20, 18, 16, 14, 12, 10, 10};
  int opk [10] = '{10, 20,  2,  4, -1, -1, -1, -1, -1, -1};
  int opc [10] = '{ 1,  2,  3,  4,  0,  0,  0,  0,  0,  0};

  initial begin
    rst = 1'b1;
    pa  = {5'd16, 5'd16};
    pb  = {5'd16, 5'd16};
    ena = 2'b11;
    enb = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d out a", i), int'(outa), 0);
      chk($sformatf("rst%0d out b", i), int'(outb), 0);
      chk($sformatf("rst%0d frame_start", i), int'(fsa | fsb), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("frame0 start a", int'(fsa), 1);
    chk("frame0 start b", int'(fsb), 1);
    chk("frame0 first out a", int'(outa), 3);

    for (int f = 0; f < 10; f++) begin
      measure(opk[f], opc[f]);
      check_frame($sformatf("F%0d", f), ea0[f], ea1[f], eb0[f], 26);
    end

    // Now at cnt=1 of a fresh frame; go to cnt=50 and reset there.
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out a", int'(outa), 0);
    chk("midrst out b", int'(outb), 0);
    chk("midrst frame_start", int'(fsa | fsb), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart start a", int'(fsa), 1);
    chk("restart first out a", int'(outa), 1);

    measure(-1, 0);
    check_frame("R0", 26, 0, 26, 26);
    measure(-1, 0);
    check_frame("R1", 30, 0, 24, 26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
